mem_arb_rr: RTL and testbench
=============================

MEM_ARB_RR -- requirements
Module: mem_arb_rr

Interface
REQ-001 SHALL have parameter p_opaq_bits, default 8: upstream opaque field width.
REQ-002 SHALL have parameter p_max_outstanding, default 4: max in-flight requests per requester, range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports req0_val, req1_val, input, 1: requester i request valid.
REQ-006 SHALL have ports req0_rdy, req1_rdy, output, 1: requester i request accepted.
REQ-007 SHALL have ports req0_msg, req1_msg, input, mem request type with p_opaq_bits opaque field.
REQ-008 SHALL have ports resp0_val, resp1_val, output, 1: response valid to requester i.
REQ-009 SHALL have ports resp0_rdy, resp1_rdy, input, 1: requester i can take a response.
REQ-010 SHALL have ports resp0_msg, resp1_msg, output, mem response type with p_opaq_bits opaque field.
REQ-011 SHALL have ports mem_req_val output 1, mem_req_rdy input 1, mem_req_msg output: request type with p_opaq_bits+1 opaque field.
REQ-012 SHALL have ports mem_resp_val input 1, mem_resp_rdy output 1, mem_resp_msg input: response type with p_opaq_bits+1 opaque field.
REQ-013 SHALL have port err, output, 1: sticky flag for an unmatched response.

Function
REQ-014 SHALL treat requester i as eligible when reqi_val=1 and cnt_i < p_max_outstanding.
REQ-015 SHALL grant one eligible requester per cycle, combinationally, with zero-cycle latency and no buffering.
- One eligible requester: that requester wins.
- Both eligible: requester named by the priority pointer ptr wins.
REQ-016 SHALL drive mem_req_val=1 exactly when a grant exists; reqi_rdy = (grant==i) & mem_req_rdy.
REQ-017 SHALL never assert reqi_rdy without reqi_val, and SHALL never assert both reqi_rdy in one cycle.
REQ-018 SHALL copy the winner's message to mem_req_msg unchanged, with opaque = {i, upstream opaque}; MSB is the requester id.
REQ-019 SHALL set ptr to the non-winning requester on each mem_req fire (mem_req_val & mem_req_rdy); otherwise ptr holds.
REQ-020 SHALL route responses by opaque MSB id:
- resp{id}_val = mem_resp_val.
- mem_resp_rdy = resp{id}_rdy.
- resp{id}_msg = mem_resp_msg with the MSB stripped.
- The other resp_val = 0.
REQ-021 SHALL update 4-bit counter cnt_i each cycle:
- +1 on request fire from i.
- -1 on response fire to i.
- Unchanged if both happen in the same cycle.
REQ-022 SHALL, on a response fire to i while cnt_i==0, hold cnt_i at 0 and set err=1; err stays set until reset.
REQ-023 SHALL keep a requester at cnt_i==p_max_outstanding ineligible; the other requester still wins, regardless of ptr.
REQ-024 SHALL accept request fire and response fire in the same cycle, independently.

Reset
REQ-025 SHALL, while rst_n=0, force ptr=0, cnt_0=cnt_1=0, err=0.
REQ-026 SHALL hold outputs at reset as follows: mem_req_val follows eligibility, so 0 when no reqi_val; resp outputs are purely combinational from mem_resp.
REQ-027 SHALL apply mid-operation reset immediately; responses arriving afterwards for lost in-flight requests set err per REQ-022.

Structure
REQ-028 SHALL take the request/response message typedefs, parameterized by opaque width, from the shared memory-message package; no new package types.
REQ-029 SHALL define the counter width constant locally.
REQ-030 SHALL use one sub-module, arb_rr_2, holding ptr and the grant logic; counters, routing and err stay in the top module.

Verification
REQ-031 SHALL cover: after reset, req0_val=req1_val=1 held, mem_req_rdy=1 -> grants 0,1,0,1 on successive cycles; mem opaque MSB 0,1,0,1.
REQ-032 SHALL cover: p_max_outstanding=2, only req0_val=1, no responses -> two fires, then req0_rdy=0 with cnt_0=2; one response with MSB=0 -> req0_rdy=1 next cycle.
REQ-033 SHALL cover: mem_resp opaque=9'h1A5 -> resp1_val=1, resp1_msg opaque=8'hA5; resp1_rdy=0 -> mem_resp_rdy=0, resp0_val=0.
REQ-034 SHALL cover: request fire and response fire for requester 0 in the same cycle with cnt_0=1 -> cnt_0 stays 1.
REQ-035 SHALL cover: response with MSB=1 while cnt_1=0 -> err=1 and it stays 1; rst_n pulse low -> err=0, ptr=0.
REQ-036 SHALL cover: mem_req_rdy=0 for 3 cycles with both requesting -> no fire and ptr unchanged; the granted requester's message is held stable.

Source files
------------

// File: rtl/mem_arb_rr_pkg.sv
// Memory message layout shared by requesters, arbiter and memory.
// The opaque field sits in the MSBs so that tagging/stripping a requester id only touches the top bit.
package mem_arb_rr_pkg;

    localparam int MEM_TYPE_BITS = 3;
    localparam int MEM_ADDR_BITS = 16;
    localparam int MEM_LEN_BITS  = 2;
    localparam int MEM_TEST_BITS = 2;
    localparam int MEM_DATA_BITS = 16;

    typedef enum logic [MEM_TYPE_BITS-1:0] {
        MEM_RD  = 3'd0,
        MEM_WR  = 3'd1,
        MEM_AMO = 3'd2
    } mem_type_t;

    // Request:  {opaque, type, addr, len, data}
    function automatic int mem_req_bits(input int opaq_bits);
        return opaq_bits + MEM_TYPE_BITS + MEM_ADDR_BITS + MEM_LEN_BITS + MEM_DATA_BITS;
    endfunction

    // Response: {opaque, type, test, len, data}
    function automatic int mem_rsp_bits(input int opaq_bits);
        return opaq_bits + MEM_TYPE_BITS + MEM_TEST_BITS + MEM_LEN_BITS + MEM_DATA_BITS;
    endfunction

endpackage

// File: rtl/arb_rr_2.sv
// Two-way round-robin grant; priority pointer moves to the loser after each accepted grant.
// Latency: grant is combinational, pointer updates on the accepting clock edge.
// Backpressure: pointer and grant hold while the granted request is stalled.
module arb_rr_2 (
    input  logic clk,
    input  logic rst_n,
    input  logic elig0,
    input  logic elig1,
    input  logic fire,
    output logic gnt_vld,
    output logic gnt_id
);

    logic ptr;

    always_comb begin
        gnt_vld = elig0 | elig1;
        gnt_id  = (elig0 & elig1) ? ptr : elig1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (fire) begin
            ptr <= ~gnt_id;
        end
    end

endmodule

// File: rtl/mem_arb_rr.sv
// Two-requester round-robin memory arbiter with id-tagged responses and per-requester credit limit.
// Latency: zero-cycle request pass-through and response routing, no buffering.
// Backpressure: mem_req_rdy/resp_rdy pass straight through; a requester at its limit is held off.
module mem_arb_rr
    import mem_arb_rr_pkg::*;
#(
    parameter int p_opaq_bits       = 8,
    parameter int p_max_outstanding = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   req0_val,
    output logic                                   req0_rdy,
    input  logic [mem_req_bits(p_opaq_bits)-1:0]   req0_msg,
    input  logic                                   req1_val,
    output logic                                   req1_rdy,
    input  logic [mem_req_bits(p_opaq_bits)-1:0]   req1_msg,
    output logic                                   resp0_val,
    input  logic                                   resp0_rdy,
    output logic [mem_rsp_bits(p_opaq_bits)-1:0]   resp0_msg,
    output logic                                   resp1_val,
    input  logic                                   resp1_rdy,
    output logic [mem_rsp_bits(p_opaq_bits)-1:0]   resp1_msg,
    output logic                                   mem_req_val,
    input  logic                                   mem_req_rdy,
    output logic [mem_req_bits(p_opaq_bits+1)-1:0] mem_req_msg,
    input  logic                                   mem_resp_val,
    output logic                                   mem_resp_rdy,
    input  logic [mem_rsp_bits(p_opaq_bits+1)-1:0] mem_resp_msg,
    output logic                                   err
);

    localparam int CNT_BITS = 4;
    localparam int RSP_W    = mem_rsp_bits(p_opaq_bits);
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(p_max_outstanding);

    logic [CNT_BITS-1:0] cnt_0;
    logic [CNT_BITS-1:0] cnt_1;
    logic                elig0;
    logic                elig1;
    logic                gnt_vld;
    logic                gnt_id;
    logic                rsp_id;
    logic                rsp_fire0;
    logic                rsp_fire1;

    assign elig0 = req0_val & (cnt_0 < CNT_MAX);
    assign elig1 = req1_val & (cnt_1 < CNT_MAX);

    arb_rr_2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .elig0   (elig0),
        .elig1   (elig1),
        .fire    (mem_req_val & mem_req_rdy),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    assign mem_req_val = gnt_vld;
    assign req0_rdy    = gnt_vld & ~gnt_id & mem_req_rdy;
    assign req1_rdy    = gnt_vld &  gnt_id & mem_req_rdy;
    assign mem_req_msg = gnt_id ? {1'b1, req1_msg} : {1'b0, req0_msg};

    // The id bit we prepended on the way out comes back as the response MSB.
    assign rsp_id       = mem_resp_msg[RSP_W];
    assign resp0_val    = mem_resp_val & ~rsp_id;
    assign resp1_val    = mem_resp_val &  rsp_id;
    assign resp0_msg    = mem_resp_msg[RSP_W-1:0];
    assign resp1_msg    = mem_resp_msg[RSP_W-1:0];
    assign mem_resp_rdy = rsp_id ? resp1_rdy : resp0_rdy;
    assign rsp_fire0    = resp0_val & resp0_rdy;
    assign rsp_fire1    = resp1_val & resp1_rdy;

    function automatic logic [CNT_BITS-1:0] cnt_next(input logic [CNT_BITS-1:0] c,
                                                     input logic inc, input logic dec);
        logic [CNT_BITS-1:0] n;
        n = c;
        if (inc && !dec) n = c + 1'b1;
        if (dec && !inc && c != '0) n = c - 1'b1;
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_0 <= '0;
            cnt_1 <= '0;
            err   <= 1'b0;
        end else begin
            cnt_0 <= cnt_next(cnt_0, req0_rdy, rsp_fire0);
            cnt_1 <= cnt_next(cnt_1, req1_rdy, rsp_fire1);
            if ((rsp_fire0 && cnt_0 == '0) || (rsp_fire1 && cnt_1 == '0)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb_rr.sv
// Directed bench for mem_arb_rr with a per-cycle reference model and literal spot checks.
module tb_mem_arb_rr;
    import mem_arb_rr_pkg::*;

    localparam int OB  = 8;
    localparam int MAX = 2;
    localparam int RW  = mem_req_bits(OB);
    localparam int MW  = mem_req_bits(OB + 1);
    localparam int SW  = mem_rsp_bits(OB);
    localparam int MSW = mem_rsp_bits(OB + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_val, req1_val, req0_rdy, req1_rdy;
    logic [RW-1:0] req0_msg, req1_msg;
    logic          resp0_val, resp1_val, resp0_rdy, resp1_rdy;
    logic [SW-1:0] resp0_msg, resp1_msg;
    logic          mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic [MW-1:0] mem_req_msg;
    logic [MSW-1:0] mem_resp_msg;
    logic          err;

    int checks = 0;
    int errors = 0;

    mem_arb_rr #(.p_opaq_bits(OB), .p_max_outstanding(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] mk_req(input logic [OB-1:0] opq, input logic [15:0] addr,
                                             input logic [15:0] data);
        return {opq, MEM_RD, addr, 2'd0, data};
    endfunction

    function automatic logic [MSW-1:0] mk_rsp(input logic [OB:0] opq, input logic [15:0] data);
        return {opq, MEM_RD, 2'd0, 2'd0, data};
    endfunction

    // Reference model: outstanding counts, priority owner and sticky error.
    int m_cnt [2];
    int m_ptr;
    bit m_err;
    int elig_q[$];

    always @(negedge clk) begin
        int  winner, rid;
        bit  exp_mval, req_fire, rsp_fire;
        logic [1:0] rv, rr;
        logic [RW-1:0] wmsg;
        rv = {req1_val, req0_val};
        rr = {resp1_rdy, resp0_rdy};
        if (!rst_n) begin
            m_cnt[0] = 0; m_cnt[1] = 0; m_ptr = 0; m_err = 0;
        end
        elig_q.delete();
        for (int i = 0; i < 2; i++) if (rv[i] && m_cnt[i] < MAX) elig_q.push_back(i);
        exp_mval = elig_q.size() > 0;
        winner   = (elig_q.size() == 1) ? elig_q[0] : m_ptr;
        wmsg     = (winner == 1) ? req1_msg : req0_msg;

        chk("m_mem_req_val", mem_req_val, exp_mval);
        if (exp_mval) chk("m_mem_req_msg", mem_req_msg, {winner[0], wmsg});
        chk("m_req0_rdy", req0_rdy, exp_mval && winner == 0 && mem_req_rdy);
        chk("m_req1_rdy", req1_rdy, exp_mval && winner == 1 && mem_req_rdy);
        chk("m_rdy_excl", req0_rdy & req1_rdy, 1'b0);
        chk("m_rdy_no_val", (req0_rdy & ~req0_val) | (req1_rdy & ~req1_val), 1'b0);

        rid = int'(mem_resp_msg[MSW-1]);
        chk("m_resp0_val", resp0_val, mem_resp_val && rid == 0);
        chk("m_resp1_val", resp1_val, mem_resp_val && rid == 1);
        chk("m_mem_resp_rdy", mem_resp_rdy, rr[rid]);
        if (mem_resp_val) chk("m_resp_msg", (rid == 1) ? resp1_msg : resp0_msg, mem_resp_msg[SW-1:0]);

        chk("m_err", err, m_err);
        chk("m_cnt0", dut.cnt_0, m_cnt[0]);
        chk("m_cnt1", dut.cnt_1, m_cnt[1]);
        chk("m_ptr", dut.u_arb.ptr, m_ptr);

        if (rst_n) begin
            req_fire = exp_mval && mem_req_rdy;
            rsp_fire = mem_resp_val && rr[rid];
            if (rsp_fire && m_cnt[rid] == 0) m_err = 1;
            if (req_fire) m_ptr = 1 - winner;
            for (int i = 0; i < 2; i++) begin
                int d;
                d = ((req_fire && winner == i) ? 1 : 0) - ((rsp_fire && rid == i) ? 1 : 0);
                if (d > 0) m_cnt[i]++;
                if (d < 0 && m_cnt[i] > 0) m_cnt[i]--;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_val = 0; req1_val = 0; mem_req_rdy = 0;
        mem_resp_val = 0; mem_resp_msg = '0; resp0_rdy = 0; resp1_rdy = 0;
    endtask

    task automatic rst_pulse();
        cyc();
        rst_n = 0;
        idle_inputs();
        cyc();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        req0_msg = mk_req(8'h11, 16'h1000, 16'hAAAA);
        req1_msg = mk_req(8'h22, 16'h2000, 16'hBBBB);
        repeat (2) @(negedge clk);
        chk("rst_mem_req_val", mem_req_val, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ptr", dut.u_arb.ptr, 1'b0);
        chk("rst_cnt0", dut.cnt_0, 4'd0);
        cyc();
        rst_n = 1;

        // Both requesting, always ready: strict alternation until both hit the limit.
        req0_val = 1; req1_val = 1; mem_req_rdy = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_gnt_id", mem_req_msg[MW-1], k % 2);
            chk("alt_opaque", mem_req_msg[MW-1 -: 9], (k % 2) ? 9'h122 : 9'h011);
            cyc();
        end
        @(negedge clk);
        chk("alt_sat_val", mem_req_val, 1'b0);
        chk("alt_sat_cnt1", dut.cnt_1, 4'd2);
        rst_pulse();

        // Single requester fills its credit, one response frees a slot.
        req0_val = 1; mem_req_rdy = 1;
        @(negedge clk); chk("lim_fire1", req0_rdy, 1'b1);
        cyc();
        @(negedge clk); chk("lim_fire2", req0_rdy, 1'b1);
        cyc();
        mem_resp_val = 1; mem_resp_msg = mk_rsp(9'h033, 16'h1234); resp0_rdy = 1;
        @(negedge clk);
        chk("lim_blocked", req0_rdy, 1'b0);
        chk("lim_cnt0", dut.cnt_0, 4'd2);
        chk("lim_resp0_val", resp0_val, 1'b1);
        cyc();
        mem_resp_val = 0; resp0_rdy = 0;
        @(negedge clk);
        chk("lim_reopen", req0_rdy, 1'b1);
        chk("lim_cnt0_after", dut.cnt_0, 4'd1);
        rst_pulse();

        // Routing by id bit, stall on resp1_rdy, then unmatched response sets err.
        req0_val = 1; mem_req_rdy = 1;
        cyc();
        req0_val = 0;
        mem_resp_val = 1; mem_resp_msg = mk_rsp(9'h1A5, 16'h5A5A); resp0_rdy = 1; resp1_rdy = 0;
        @(negedge clk);
        chk("rt_ptr_moved", dut.u_arb.ptr, 1'b1);
        chk("rt_resp1_val", resp1_val, 1'b1);
        chk("rt_resp1_opaque", resp1_msg[SW-1 -: 8], 8'hA5);
        chk("rt_resp1_data", resp1_msg[15:0], 16'h5A5A);
        chk("rt_mem_resp_rdy", mem_resp_rdy, 1'b0);
        chk("rt_resp0_val", resp0_val, 1'b0);
        cyc();
        resp1_rdy = 1;
        @(negedge clk);
        chk("rt_err_before", err, 1'b0);
        cyc();
        mem_resp_val = 0; resp1_rdy = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("err_sticky", err, 1'b1);
            chk("err_cnt1", dut.cnt_1, 4'd0);
            cyc();
        end
        rst_n = 0;
        @(negedge clk);
        chk("err_cleared", err, 1'b0);
        chk("ptr_cleared", dut.u_arb.ptr, 1'b0);
        cyc();
        rst_n = 1;

        // Request and response fire together for requester 0.
        req0_val = 1; mem_req_rdy = 1;
        cyc();
        mem_resp_val = 1; mem_resp_msg = mk_rsp(9'h044, 16'h0F0F); resp0_rdy = 1;
        @(negedge clk);
        chk("both_cnt0_pre", dut.cnt_0, 4'd1);
        chk("both_req_fire", req0_rdy, 1'b1);
        chk("both_rsp_fire", mem_resp_rdy, 1'b1);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("both_cnt0_post", dut.cnt_0, 4'd1);
        rst_pulse();

        // Stalled memory: no fire, pointer and granted message hold.
        req0_val = 1; req1_val = 1; mem_req_rdy = 1;
        cyc();
        mem_req_rdy = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_rdy0", req0_rdy, 1'b0);
            chk("stall_rdy1", req1_rdy, 1'b0);
            chk("stall_val", mem_req_val, 1'b1);
            chk("stall_ptr", dut.u_arb.ptr, 1'b1);
            chk("stall_opaque", mem_req_msg[MW-1 -: 9], 9'h122);
            chk("stall_data", mem_req_msg[15:0], 16'hBBBB);
            cyc();
        end
        mem_req_rdy = 1;
        @(negedge clk);
        chk("stall_release", req1_rdy, 1'b1);
        cyc();
        req0_val = 0; req1_val = 0;
        @(negedge clk);
        chk("stall_ptr_after", dut.u_arb.ptr, 1'b0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
